control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Parametrised successor to the fixed-step control decoder.
- Owns its step counter and a fetch/decode/execute FSM.
- Decodes a 4-bit opcode into per-step control strobes and a bus selector.
- Adds conditional branches on latched flags, OUT, a sticky halt and a single-step debug mode.
- Sits between the instruction register, ALU flags and all bus-attached registers of the CPU.

Parameters:
- INSTR_W, 8: instruction width; opcode = instruction[INSTR_W-1 -: 4]. Must be ≥ 5.
- BUS_SEL_W, 3: bus_selector width. Must be ≥ 3.

Ports:
- clk  in  1  system clock, rising edge.
- bReset  in  1  asynchronous, active-high reset.
- instruction  in  INSTR_W  instruction register contents.
- flag_zero  in  1  ALU zero flag register.
- flag_carry  in  1  ALU carry flag register.
- step_mode  in  1  1 = pause after every instruction.
- step_go  in  1  1-cycle pulse; releases one instruction in step mode.
- hlt, memory_in, ram_in, instruction_in, reg_a_in, reg_b_in, out_in, advance_pc, pc_in, flags_in  out  1 each  register/control strobes.
- alu_mode  out  3  ALU operation select.
- bus_selector  out  BUS_SEL_W  bus driver: 0 NONE, 1 PC, 2 RAM, 3 IR operand, 4 REG_A, 5 ALU.
- sc  out  3  current step index, 0–5.
- busy  out  1  1 unless in PAUSE or HALT.

Behaviour:
- FSM states: PAUSE, T0, T1, T2, T3, T4, T5, HALT.
- State, latched opcode and latched flags are registered. Outputs are decoded from registered state only (Moore).
- Every output not listed for a step is 0.

Reset:
- bReset forces state PAUSE and clears latched opcode and flags.
- All outputs are 0 while reset is asserted and after it, including sc=0, busy=0, hlt=0.
- Reset mid-instruction aborts the instruction immediately; no partial strobe survives.

PAUSE:
- Moves to T0 when step_mode==0 or step_go==1.
- In normal mode, the first T0 therefore occurs 1 cycle after reset release.

Fetch and decode:
- T0: bus_selector=PC, memory_in=1.
- T1: bus_selector=RAM, instruction_in=1, advance_pc=1.
- T2: no strobes. Latch opcode from instruction, and latch flag_zero/flag_carry.
- Branch decisions use only these T2-latched values.

Execute (opcodes):
- 0xxx ALU:
  - T3: IR operand → memory_in.
  - T4: RAM → reg_b_in.
  - T5: ALU → reg_a_in, flags_in=1, alu_mode=opcode[2:0].
- 1000 LOAD:
  - T3: IR operand → memory_in.
  - T4: RAM → reg_a_in.
- 1001 STORE:
  - T3: IR operand → memory_in.
  - T4: REG_A on bus, ram_in=1.
- 1010 JMP: T3: IR operand → pc_in.
- 1011 BEQ: T3: pc_in with IR operand only if latched zero=1; otherwise no strobes.
- 1100 BCS: same as BEQ, using latched carry.
- 1110 OUT: T3: REG_A → out_in.
- 1101 NOP: T3, no strobes.
- 1111 HLT: T3 asserts hlt, then goes to HALT. HALT holds hlt=1 with all other outputs 0 until bReset. step_go and step_mode are ignored in HALT.

End of instruction and timing:
- After the last step of an instruction, go to T0 if step_mode==0, else PAUSE.
- Instruction length: ALU 6 cycles, LOAD/STORE 5, all others 4.
- sc = step index in T0–T5, 0 in PAUSE/HALT.
- step_mode changes take effect only at an instruction boundary.
- step_go outside PAUSE is ignored; it is neither queued nor counted.
- step_go held high in PAUSE releases exactly one instruction per return to PAUSE.

Test Plan:
- Reset then idle, step_mode=0: all outputs 0 during reset. First cycle after release is PAUSE; then T0 with bus_selector=1, memory_in=1, sc=0.
- instruction=8'h1A (SUB, operand 0xA): T3 bus=3/memory_in; T4 bus=2/reg_b_in; T5 bus=5/reg_a_in/flags_in/alu_mode=3'b001. Next cycle is T0.
- BEQ 8'hB7 with flag_zero=1 at T2 and flag_zero dropped to 0 at T3 → pc_in=1, bus=3 in T3. Repeat with flag_zero=0 at T2 → no strobes in T3.
- STORE 8'h95 → T4 bus_selector=4, ram_in=1, memory_in=0. Then HLT 8'hF0 → hlt=1 from T3 onward, held for 20 cycles despite step_go pulses. busy=0 in HALT.
- step_mode=1 with a JMP: after T3 the FSM holds PAUSE (busy=0, sc=0) for 10 cycles. A step_go pulse gives T0 on the next cycle. step_go asserted during T1 has no effect.
- Assert bReset during T4 of a LOAD: all strobes drop in the same cycle. After release, sequence restarts PAUSE→T0 with opcode cleared.

Source files
------------

// File: rtl/control_sequencer.sv
// Instruction sequencer: fetch/decode/execute FSM that turns a latched opcode and flags
// into per-step register strobes, a bus selector, and halt/single-step control.
module control_sequencer #(
    parameter int INSTR_W   = 8,
    parameter int BUS_SEL_W = 3
) (
    input  logic                 clk,
    input  logic                 bReset,
    input  logic [INSTR_W-1:0]   instruction,
    input  logic                 flag_zero,
    input  logic                 flag_carry,
    input  logic                 step_mode,
    input  logic                 step_go,
    output logic                 hlt,
    output logic                 memory_in,
    output logic                 ram_in,
    output logic                 instruction_in,
    output logic                 reg_a_in,
    output logic                 reg_b_in,
    output logic                 out_in,
    output logic                 advance_pc,
    output logic                 pc_in,
    output logic                 flags_in,
    output logic [2:0]           alu_mode,
    output logic [BUS_SEL_W-1:0] bus_selector,
    output logic [2:0]           sc,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_PAUSE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
    } state_t;

    typedef struct packed {
        logic                 hlt;
        logic                 memory_in;
        logic                 ram_in;
        logic                 instruction_in;
        logic                 reg_a_in;
        logic                 reg_b_in;
        logic                 out_in;
        logic                 advance_pc;
        logic                 pc_in;
        logic                 flags_in;
        logic [2:0]           alu_mode;
        logic [BUS_SEL_W-1:0] bus_sel;
        logic [2:0]           sc;
        logic                 busy;
    } ctrl_t;

    localparam logic [BUS_SEL_W-1:0] BUS_NONE = BUS_SEL_W'(0);
    localparam logic [BUS_SEL_W-1:0] BUS_PC   = BUS_SEL_W'(1);
    localparam logic [BUS_SEL_W-1:0] BUS_RAM  = BUS_SEL_W'(2);
    localparam logic [BUS_SEL_W-1:0] BUS_IR   = BUS_SEL_W'(3);
    localparam logic [BUS_SEL_W-1:0] BUS_REGA = BUS_SEL_W'(4);
    localparam logic [BUS_SEL_W-1:0] BUS_ALU  = BUS_SEL_W'(5);

    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_BEQ   = 4'hB;
    localparam logic [3:0] OP_BCS   = 4'hC;
    localparam logic [3:0] OP_NOP   = 4'hD;
    localparam logic [3:0] OP_OUT   = 4'hE;
    localparam logic [3:0] OP_HLT   = 4'hF;

    state_t     r_state;
    logic [3:0] r_opcode;
    logic       r_zero;
    logic       r_carry;
    ctrl_t      r_ctrl;

    state_t     w_state_next;
    state_t     w_end_state;
    logic [3:0] w_opcode_next;
    logic       w_zero_next;
    logic       w_carry_next;
    logic       w_has_t4;
    ctrl_t      w_ctrl;
    logic       w_unused_operand;

    // Operand bits travel on the bus via the IR itself; the sequencer only needs the opcode.
    assign w_unused_operand = ^instruction[INSTR_W-5:0];

    // Moore decode; applied to the next state so the registered outputs line up with it.
    function automatic ctrl_t f_decode(state_t st, logic [3:0] op, logic z, logic c);
        ctrl_t d;
        d = '0;
        case (st)
            S_T0: begin
                d.busy = 1'b1; d.sc = 3'd0;
                d.bus_sel = BUS_PC; d.memory_in = 1'b1;
            end
            S_T1: begin
                d.busy = 1'b1; d.sc = 3'd1;
                d.bus_sel = BUS_RAM; d.instruction_in = 1'b1; d.advance_pc = 1'b1;
            end
            S_T2: begin
                d.busy = 1'b1; d.sc = 3'd2;
            end
            S_T3: begin
                d.busy = 1'b1; d.sc = 3'd3;
                if (!op[3] || op == OP_LOAD || op == OP_STORE) begin
                    d.bus_sel = BUS_IR; d.memory_in = 1'b1;
                end else begin
                    case (op)
                        OP_JMP: begin d.bus_sel = BUS_IR; d.pc_in = 1'b1; end
                        OP_BEQ: if (z) begin d.bus_sel = BUS_IR; d.pc_in = 1'b1; end
                        OP_BCS: if (c) begin d.bus_sel = BUS_IR; d.pc_in = 1'b1; end
                        OP_OUT: begin d.bus_sel = BUS_REGA; d.out_in = 1'b1; end
                        OP_HLT: d.hlt = 1'b1;
                        default: d.hlt = 1'b0;
                    endcase
                end
            end
            S_T4: begin
                d.busy = 1'b1; d.sc = 3'd4;
                if (!op[3]) begin
                    d.bus_sel = BUS_RAM; d.reg_b_in = 1'b1;
                end else if (op == OP_LOAD) begin
                    d.bus_sel = BUS_RAM; d.reg_a_in = 1'b1;
                end else if (op == OP_STORE) begin
                    d.bus_sel = BUS_REGA; d.ram_in = 1'b1;
                end
            end
            S_T5: begin
                d.busy = 1'b1; d.sc = 3'd5;
                d.bus_sel = BUS_ALU; d.reg_a_in = 1'b1; d.flags_in = 1'b1;
                d.alu_mode = op[2:0];
            end
            S_HALT: d.hlt = 1'b1;
            default: d.bus_sel = BUS_NONE;
        endcase
        return d;
    endfunction

    assign w_end_state = step_mode ? S_PAUSE : S_T0;
    assign w_has_t4    = !r_opcode[3] || r_opcode == OP_LOAD || r_opcode == OP_STORE;

    always_comb begin
        w_state_next  = r_state;
        w_opcode_next = r_opcode;
        w_zero_next   = r_zero;
        w_carry_next  = r_carry;
        case (r_state)
            S_PAUSE: if (!step_mode || step_go) w_state_next = S_T0;
            S_T0:    w_state_next = S_T1;
            S_T1:    w_state_next = S_T2;
            S_T2: begin
                w_state_next  = S_T3;
                w_opcode_next = instruction[INSTR_W-1 -: 4];
                w_zero_next   = flag_zero;
                w_carry_next  = flag_carry;
            end
            S_T3: begin
                if (r_opcode == OP_HLT)  w_state_next = S_HALT;
                else if (w_has_t4)       w_state_next = S_T4;
                else                     w_state_next = w_end_state;
            end
            S_T4:    w_state_next = r_opcode[3] ? w_end_state : S_T5;
            S_T5:    w_state_next = w_end_state;
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_PAUSE;
        endcase
    end

    assign w_ctrl = f_decode(w_state_next, w_opcode_next, w_zero_next, w_carry_next);

    always_ff @(posedge clk or posedge bReset) begin
        if (bReset) begin
            r_state  <= S_PAUSE;
            r_opcode <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_ctrl   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_opcode <= w_opcode_next;
            r_zero   <= w_zero_next;
            r_carry  <= w_carry_next;
            r_ctrl   <= w_ctrl;
        end
    end

    assign hlt            = r_ctrl.hlt;
    assign memory_in      = r_ctrl.memory_in;
    assign ram_in         = r_ctrl.ram_in;
    assign instruction_in = r_ctrl.instruction_in;
    assign reg_a_in       = r_ctrl.reg_a_in;
    assign reg_b_in       = r_ctrl.reg_b_in;
    assign out_in         = r_ctrl.out_in;
    assign advance_pc     = r_ctrl.advance_pc;
    assign pc_in          = r_ctrl.pc_in;
    assign flags_in       = r_ctrl.flags_in;
    assign alu_mode       = r_ctrl.alu_mode;
    assign bus_selector   = r_ctrl.bus_sel;
    assign sc             = r_ctrl.sc;
    assign busy           = r_ctrl.busy;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: an instruction-level model predicts every output each cycle,
// and directed literal checks pin the key steps of each scenario.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       bReset = 1'b1;
    logic [7:0] instruction = 8'hD0;
    logic       flag_zero = 1'b0;
    logic       flag_carry = 1'b0;
    logic       step_mode = 1'b0;
    logic       step_go = 1'b0;

    logic       hlt, memory_in, ram_in, instruction_in, reg_a_in, reg_b_in;
    logic       out_in, advance_pc, pc_in, flags_in, busy;
    logic [2:0] alu_mode, bus_selector, sc;

    int n_tests = 0;
    int n_fail  = 0;

    control_sequencer #(.INSTR_W(8), .BUS_SEL_W(3)) dut (
        .clk(clk), .bReset(bReset), .instruction(instruction),
        .flag_zero(flag_zero), .flag_carry(flag_carry),
        .step_mode(step_mode), .step_go(step_go),
        .hlt(hlt), .memory_in(memory_in), .ram_in(ram_in),
        .instruction_in(instruction_in), .reg_a_in(reg_a_in), .reg_b_in(reg_b_in),
        .out_in(out_in), .advance_pc(advance_pc), .pc_in(pc_in), .flags_in(flags_in),
        .alu_mode(alu_mode), .bus_selector(bus_selector), .sc(sc), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [19:0] dut_vec;
    assign dut_vec = {hlt, memory_in, ram_in, instruction_in, reg_a_in, reg_b_in,
                      out_in, advance_pc, pc_in, flags_in, alu_mode, bus_selector, sc, busy};

    // Model: m_pos is the step within the current instruction, -1 when paused or halted.
    int         m_pos = -1;
    bit         m_halted = 1'b0;
    logic [3:0] m_op = 4'h0;
    logic       m_z = 1'b0;
    logic       m_c = 1'b0;

    function automatic int instr_len(logic [3:0] op);
        if (!op[3]) return 6;
        if (op == 4'h8 || op == 4'h9) return 5;
        return 4;
    endfunction

    function automatic logic [19:0] exp_vec(int pos, bit halted, logic [3:0] op, logic z, logic c);
        logic e_hlt, e_mi, e_ri, e_ii, e_ra, e_rb, e_oi, e_apc, e_pci, e_fi, e_busy;
        logic [2:0] e_alu, e_bus, e_sc;
        {e_hlt, e_mi, e_ri, e_ii, e_ra, e_rb, e_oi, e_apc, e_pci, e_fi, e_busy} = '0;
        e_alu = 3'd0; e_bus = 3'd0; e_sc = 3'd0;
        if (halted) begin
            e_hlt = 1'b1;
        end else if (pos >= 0) begin
            e_busy = 1'b1;
            e_sc   = 3'(pos);
            if (pos == 0) begin e_bus = 3'd1; e_mi = 1'b1; end
            if (pos == 1) begin e_bus = 3'd2; e_ii = 1'b1; e_apc = 1'b1; end
            if (pos == 3) begin
                if (!op[3] || op == 4'h8 || op == 4'h9) begin e_bus = 3'd3; e_mi = 1'b1; end
                if (op == 4'hA || (op == 4'hB && z) || (op == 4'hC && c)) begin
                    e_bus = 3'd3; e_pci = 1'b1;
                end
                if (op == 4'hE) begin e_bus = 3'd4; e_oi = 1'b1; end
                if (op == 4'hF) e_hlt = 1'b1;
            end
            if (pos == 4) begin
                if (!op[3])          begin e_bus = 3'd2; e_rb = 1'b1; end
                else if (op == 4'h8) begin e_bus = 3'd2; e_ra = 1'b1; end
                else if (op == 4'h9) begin e_bus = 3'd4; e_ri = 1'b1; end
            end
            if (pos == 5) begin e_bus = 3'd5; e_ra = 1'b1; e_fi = 1'b1; e_alu = op[2:0]; end
        end
        return {e_hlt, e_mi, e_ri, e_ii, e_ra, e_rb, e_oi, e_apc, e_pci, e_fi,
                e_alu, e_bus, e_sc, e_busy};
    endfunction

    always @(posedge clk or posedge bReset) begin
        if (bReset) begin
            m_pos <= -1; m_halted <= 1'b0; m_op <= 4'h0; m_z <= 1'b0; m_c <= 1'b0;
        end else if (!m_halted) begin
            if (m_pos < 0) begin
                if (!step_mode || step_go) m_pos <= 0;
            end else if (m_pos == 2) begin
                m_op <= instruction[7:4]; m_z <= flag_zero; m_c <= flag_carry;
                m_pos <= 3;
            end else if (m_pos == instr_len(m_op) - 1) begin
                if (m_op == 4'hF) begin
                    m_halted <= 1'b1; m_pos <= -1;
                end else begin
                    m_pos <= step_mode ? -1 : 0;
                end
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    always @(negedge clk) begin : cycle_cmp
        logic [19:0] e;
        e = exp_vec(m_pos, m_halted, m_op, m_z, m_c);
        n_tests++;
        if (dut_vec !== e) begin
            n_fail++;
            $display("FAIL cycle_model t=%0t got=%05h expected=%05h", $time, dut_vec, e);
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pos(int p);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (m_pos == p) found = 1'b1;
        end
        if (!found) begin
            n_tests++; n_fail++;
            $display("FAIL wait_pos_%0d timeout t=%0t", p, $time);
        end
    endtask

    initial begin
        repeat (2) step();
        chk("reset_all_zero", 32'(dut_vec), 32'h0);
        bReset = 1'b0;
        chk("pause_after_release", 32'(dut_vec), 32'h0);
        step();
        chk("t0_bus_pc", 32'(bus_selector), 32'd1);
        chk("t0_memory_in", 32'(memory_in), 32'd1);
        chk("t0_sc", 32'(sc), 32'd0);
        chk("t0_busy", 32'(busy), 32'd1);

        wait_pos(2); instruction = 8'h1A;
        step(); chk("sub_t3_bus", 32'(bus_selector), 32'd3); chk("sub_t3_mi", 32'(memory_in), 32'd1);
        step(); chk("sub_t4_bus", 32'(bus_selector), 32'd2); chk("sub_t4_rb", 32'(reg_b_in), 32'd1);
        step(); chk("sub_t5_bus", 32'(bus_selector), 32'd5); chk("sub_t5_ra", 32'(reg_a_in), 32'd1);
        chk("sub_t5_flags", 32'(flags_in), 32'd1); chk("sub_t5_alu", 32'(alu_mode), 32'd1);
        step(); chk("sub_next_t0", 32'(memory_in), 32'd1); chk("sub_next_sc", 32'(sc), 32'd0);

        wait_pos(2); instruction = 8'hB7; flag_zero = 1'b1;
        step(); flag_zero = 1'b0;
        chk("beq_taken_pc_in", 32'(pc_in), 32'd1); chk("beq_taken_bus", 32'(bus_selector), 32'd3);
        wait_pos(2); instruction = 8'hB7; flag_zero = 1'b0;
        step(); chk("beq_not_pc_in", 32'(pc_in), 32'd0); chk("beq_not_bus", 32'(bus_selector), 32'd0);
        wait_pos(2); instruction = 8'hC4; flag_carry = 1'b1;
        step(); flag_carry = 1'b0; chk("bcs_taken_pc_in", 32'(pc_in), 32'd1);
        wait_pos(2); instruction = 8'hE0;
        step(); chk("out_in", 32'(out_in), 32'd1); chk("out_bus", 32'(bus_selector), 32'd4);
        wait_pos(2); instruction = 8'h6C;

        wait_pos(2); instruction = 8'hA3; step_mode = 1'b1;
        step(); chk("jmp_pc_in", 32'(pc_in), 32'd1); instruction = 8'hD0;
        for (int i = 0; i < 10; i++) begin
            step(); chk("pause_busy", 32'(busy), 32'd0); chk("pause_sc", 32'(sc), 32'd0);
        end
        step_go = 1'b1; step(); step_go = 1'b0;
        chk("go_t0_mi", 32'(memory_in), 32'd1); chk("go_t0_busy", 32'(busy), 32'd1);
        step(); chk("go_t1_ii", 32'(instruction_in), 32'd1); step_go = 1'b1;
        step(); step_go = 1'b0;
        step(); step();
        chk("go_ignored_busy", 32'(busy), 32'd0);
        step(); chk("go_not_queued", 32'(busy), 32'd0);
        step_go = 1'b1; repeat (12) step(); step_go = 1'b0;
        wait_pos(-1); step_mode = 1'b0;

        wait_pos(2); instruction = 8'h84;
        step(); step();
        chk("load_t4_ra", 32'(reg_a_in), 32'd1); chk("load_t4_bus", 32'(bus_selector), 32'd2);
        bReset = 1'b1; #1;
        chk("abort_all_zero", 32'(dut_vec), 32'h0);
        step(); bReset = 1'b0; chk("abort_pause", 32'(dut_vec), 32'h0);
        step(); chk("abort_restart_t0", 32'(memory_in), 32'd1);

        wait_pos(2); instruction = 8'h95;
        step(); step();
        chk("store_bus", 32'(bus_selector), 32'd4); chk("store_ram_in", 32'(ram_in), 32'd1);
        chk("store_mi", 32'(memory_in), 32'd0);
        wait_pos(2); instruction = 8'hF0;
        step(); chk("hlt_t3", 32'(hlt), 32'd1);
        for (int i = 0; i < 20; i++) begin
            step_go = i[0]; step_mode = i[1];
            step(); chk("halt_hlt", 32'(hlt), 32'd1); chk("halt_busy", 32'(busy), 32'd0);
        end
        step_go = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
